// File: rtl/riscv_decode_issue_pkg.sv
// Shared RV32I decode constants and the issue-slot record used by riscv_decode_issue.
// Opcode, ALU funct3 and branch funct3 codes live here so all stages agree on them.
package riscv_decode_issue_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] RISC_ADD_OP  = 3'b000;
    localparam logic [2:0] RISC_SLL_OP  = 3'b001;
    localparam logic [2:0] RISC_SLT_OP  = 3'b010;
    localparam logic [2:0] RISC_SLTU_OP = 3'b011;
    localparam logic [2:0] RISC_XOR_OP  = 3'b100;
    localparam logic [2:0] RISC_SR_OP   = 3'b101;
    localparam logic [2:0] RISC_OR_OP   = 3'b110;
    localparam logic [2:0] RISC_AND_OP  = 3'b111;

    localparam logic [2:0] BEQ   = 3'b000;
    localparam logic [2:0] BNE   = 3'b001;
    localparam logic [2:0] BLT   = 3'b100;
    localparam logic [2:0] BGE   = 3'b101;
    localparam logic [2:0] BLTU  = 3'b110;
    localparam logic [2:0] BGETU = 3'b111;

    localparam logic [9:0] ALU_FUNC_ADD = 10'h000;
    // funct7[5] sits at func[8]; it selects SRA in the ALU and must be clear for SUB
    localparam logic [9:0] ALU_FUNC_ALT = 10'h100;

    typedef struct packed {
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [9:0]  alu_func;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic        is_branch;
        logic        illegal;
        logic [31:0] branch_target;
        logic [31:0] pc;
    } issue_t;

    // SLT/SLTU have no ALU support; the same codes are unused branch conditions
    function automatic logic f3_supported(input logic [2:0] f3);
        return (f3 != RISC_SLT_OP) && (f3 != RISC_SLTU_OP);
    endfunction

endpackage

// File: rtl/riscv_decode_issue_imm_gen.sv
// Immediate extraction for RV32I I-, B- and U-type formats (purely combinational).
import riscv_decode_issue_pkg::*;

module riscv_imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

endmodule

// File: rtl/riscv_decode_issue.sv
// RV32I decode/issue stage: one registered issue slot feeding the ALU, with stall and flush.
// Optional macro DECODE_SKID_EN adds an input skid entry so in_ready comes from a flop.
import riscv_decode_issue_pkg::*;

module riscv_decode_issue #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [9:0]      alu_func,
    output logic [4:0]      rd_addr,
    output logic            rd_we,
    output logic            is_branch,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] out_pc,
    output logic            illegal
);

    localparam issue_t SLOT_RESET = '{
        alu_a: '0, alu_b: '0, alu_func: '0, rd_addr: '0, rd_we: 1'b0,
        is_branch: 1'b0, illegal: 1'b0, branch_target: '0, pc: PC_RESET
    };

    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_rs1;
    logic [31:0] d_rs2;
    logic        load_p0;
    logic        valid_p1;
    issue_t      dec_p0;
    issue_t      slot_p1;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

`ifdef DECODE_SKID_EN
    logic        skid_full;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] skid_rs1;
    logic [31:0] skid_rs2;
    logic        slot_free;
    logic        park;

    assign in_ready  = ~skid_full;
    assign slot_free = ~valid_p1 | out_ready;
    assign d_instr   = skid_full ? skid_instr : in_instr;
    assign d_pc      = skid_full ? skid_pc    : in_pc;
    assign d_rs1     = skid_full ? skid_rs1   : rs1_data;
    assign d_rs2     = skid_full ? skid_rs2   : rs2_data;
    assign load_p0   = (skid_full | in_valid) & slot_free & ~flush;
    assign park      = in_valid & ~skid_full & ~slot_free & ~flush;

    // The parked entry keeps its register operands, so the regfile may move on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full  <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_rs1   <= '0;
            skid_rs2   <= '0;
        end else if (flush) begin
            skid_full <= 1'b0;
        end else if (park) begin
            skid_full  <= 1'b1;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            skid_rs1   <= rs1_data;
            skid_rs2   <= rs2_data;
        end else if (skid_full && slot_free) begin
            skid_full <= 1'b0;
        end
    end
`else
    assign in_ready = ~valid_p1 | out_ready;
    assign d_instr  = in_instr;
    assign d_pc     = in_pc;
    assign d_rs1    = rs1_data;
    assign d_rs2    = rs2_data;
    assign load_p0  = in_valid & in_ready & ~flush;
`endif

    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;

    riscv_imm_gen u_imm_gen (
        .instr (d_instr),
        .imm_i (imm_i),
        .imm_b (imm_b),
        .imm_u (imm_u)
    );

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       writes_rd;

    assign opcode = d_instr[6:0];
    assign funct3 = d_instr[14:12];
    assign funct7 = d_instr[31:25];

    always_comb begin
        dec_p0               = '0;
        writes_rd            = 1'b0;
        dec_p0.pc            = d_pc;
        dec_p0.rd_addr       = d_instr[11:7];
        dec_p0.branch_target = d_pc + imm_b;
        case (opcode)
            OPC_OP: begin
                if (!f3_supported(funct3)) begin
                    dec_p0.illegal = 1'b1;
                end else begin
                    writes_rd    = 1'b1;
                    dec_p0.alu_a = d_rs1;
                    // SUB becomes an add of the two's complement, so the alt bit is dropped
                    if (funct7[5] && funct3 == RISC_ADD_OP) begin
                        dec_p0.alu_b    = ~d_rs2 + 32'd1;
                        dec_p0.alu_func = {funct7, funct3} & ~ALU_FUNC_ALT;
                    end else begin
                        dec_p0.alu_b    = d_rs2;
                        dec_p0.alu_func = {funct7, funct3};
                    end
                end
            end
            OPC_OP_IMM: begin
                if (!f3_supported(funct3)) begin
                    dec_p0.illegal = 1'b1;
                end else begin
                    writes_rd    = 1'b1;
                    dec_p0.alu_a = d_rs1;
                    if (funct3 == RISC_SLL_OP || funct3 == RISC_SR_OP) begin
                        dec_p0.alu_b    = {27'b0, d_instr[24:20]};
                        dec_p0.alu_func = {funct7, funct3};
                    end else begin
                        dec_p0.alu_b    = imm_i;
                        dec_p0.alu_func = {7'b0, funct3};
                    end
                end
            end
            OPC_BRANCH: begin
                if (!f3_supported(funct3)) begin
                    dec_p0.illegal = 1'b1;
                end else begin
                    dec_p0.alu_a     = d_rs1;
                    dec_p0.alu_b     = d_rs2;
                    dec_p0.alu_func  = {7'b0, funct3};
                    dec_p0.is_branch = 1'b1;
                end
            end
            OPC_LUI: begin
                writes_rd       = 1'b1;
                dec_p0.alu_a    = '0;
                dec_p0.alu_b    = imm_u;
                dec_p0.alu_func = ALU_FUNC_ADD;
            end
            OPC_AUIPC: begin
                writes_rd       = 1'b1;
                dec_p0.alu_a    = d_pc;
                dec_p0.alu_b    = imm_u;
                dec_p0.alu_func = ALU_FUNC_ADD;
            end
            default: begin
                dec_p0.illegal = 1'b1;
            end
        endcase
        dec_p0.rd_we = writes_rd & (d_instr[11:7] != 5'd0);
    end

    // ---- p0 -> p1 : issue slot register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_p1 <= 1'b0;
            slot_p1  <= SLOT_RESET;
        end else begin
            if (flush) begin
                valid_p1 <= 1'b0;
            end else if (load_p0) begin
                valid_p1 <= 1'b1;
            end else if (out_ready) begin
                valid_p1 <= 1'b0;
            end
            if (load_p0) begin
                slot_p1 <= dec_p0;
            end
        end
    end

    assign out_valid     = valid_p1;
    assign alu_a         = slot_p1.alu_a;
    assign alu_b         = slot_p1.alu_b;
    assign alu_func      = slot_p1.alu_func;
    assign rd_addr       = slot_p1.rd_addr;
    assign rd_we         = slot_p1.rd_we;
    assign is_branch     = slot_p1.is_branch;
    assign illegal       = slot_p1.illegal;
    assign branch_target = slot_p1.branch_target;
    assign out_pc        = slot_p1.pc;

endmodule

// File: tb/tb_riscv_decode_issue.sv
// Bench for riscv_decode_issue: directed steps then random traffic against a behavioural model.
module tb_riscv_decode_issue;

    localparam logic [31:0] PC_RST = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [9:0]  alu_func;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        is_branch;
    logic [31:0] branch_target;
    logic [31:0] out_pc;
    logic        illegal;

    logic [31:0] regs [32];

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    always #5 clk = ~clk;

    riscv_decode_issue #(.XLEN(32), .PC_RESET(PC_RST)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .rd_addr(rd_addr), .rd_we(rd_we), .is_branch(is_branch),
        .branch_target(branch_target), .out_pc(out_pc), .illegal(illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [9:0]  func;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic        ill;
        logic [31:0] tgt;
        logic [31:0] pc;
    } exp_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_valid;
    exp_t exp_cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference decode written straight from the ISA rules with plain arithmetic
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int off;
        logic wr;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        wr  = 1'b0;
        e   = '0;
        off = int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        if (ins[31]) off = off - 8192;
        e.tgt = pc + off;
        e.pc  = pc;
        e.rd  = ins[11:7];
        if (op == 7'h33 || op == 7'h13 || op == 7'h63) begin
            if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
        end else if (op != 7'h37 && op != 7'h17) begin
            e.ill = 1'b1;
        end
        if (!e.ill) begin
            case (op)
                7'h33: begin
                    wr = 1'b1; e.a = r1;
                    if (f7[5] && f3 == 3'd0) begin e.b = 32'd0 - r2; e.func = {f7 & 7'b1011111, f3}; end
                    else begin e.b = r2; e.func = {f7, f3}; end
                end
                7'h13: begin
                    wr = 1'b1; e.a = r1;
                    if (f3 == 3'd1 || f3 == 3'd5) begin e.b = 32'(ins[24:20]); e.func = {f7, f3}; end
                    else begin e.b = 32'($signed(ins) >>> 20); e.func = {7'd0, f3}; end
                end
                7'h63: begin e.a = r1; e.b = r2; e.func = {7'd0, f3}; e.br = 1'b1; end
                7'h37: begin wr = 1'b1; e.a = 0; e.b = ins & 32'hFFFF_F000; e.func = 0; end
                default: begin wr = 1'b1; e.a = pc; e.b = ins & 32'hFFFF_F000; e.func = 0; end
            endcase
        end
        e.we = wr && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'h63};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 7)
            0: return enc_r(($urandom % 2) ? 7'h20 : 7'h00, r[24:20], r[19:15], r[14:12], r[11:7]);
            1: return enc_i(r[31:20], r[19:15], r[14:12], r[11:7]);
            2: return enc_i({($urandom % 2) ? 7'h20 : 7'h00, r[24:20]}, r[19:15],
                            ($urandom % 2) ? 3'd5 : 3'd1, r[11:7]);
            3: return {r[31:7], 7'h63};
            4: return {r[31:7], 7'h37};
            5: return {r[31:7], 7'h17};
            default: return r;
        endcase
    endfunction

    task automatic check_slot();
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_pc", out_pc, exp_cur.pc);
            chk("rd_addr", 32'(rd_addr), 32'(exp_cur.rd));
            chk("rd_we", 32'(rd_we), 32'(exp_cur.we));
            chk("is_branch", 32'(is_branch), 32'(exp_cur.br));
            chk("illegal", 32'(illegal), 32'(exp_cur.ill));
            chk("branch_target", branch_target, exp_cur.tgt);
            if (!exp_cur.ill) begin
                chk("alu_a", alu_a, exp_cur.a);
                chk("alu_b", alu_b, exp_cur.b);
                chk("alu_func", 32'(alu_func), 32'(exp_cur.func));
            end
        end
    endtask

    // Inputs are driven at posedge+1; in_ready is checked at posedge+4, outputs at the next posedge+1
    task automatic cycle();
        exp_t nxt;
        logic nv;
        logic rdy;
        #3;
        rdy = !exp_valid || out_ready;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        nv  = exp_valid;
        nxt = exp_cur;
        if (flush) begin
            nv = 1'b0;
        end else if (rdy) begin
            nv = in_valid;
            if (in_valid) nxt = model(in_instr, in_pc, regs[in_instr[19:15]], regs[in_instr[24:20]]);
        end
        @(posedge clk);
        #1;
        exp_valid = nv;
        exp_cur   = nxt;
        check_slot();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rd_we"}, 32'(rd_we), 32'd0);
        chk({tag, "_is_branch"}, 32'(is_branch), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_func"}, 32'(alu_func), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_branch_target"}, branch_target, 32'd0);
        chk({tag, "_out_pc"}, out_pc, PC_RST);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_pc = 32'd0;
        exp_valid = 1'b0; exp_cur = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        regs[1] = 32'd5; regs[2] = 32'd7;
        in_valid = 1'b1; in_pc = 32'h40;
        in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        cycle();
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_rd_we", 32'(rd_we), 32'd1);

        in_instr = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
        cycle();
        chk("sub_b", alu_b, 32'hFFFF_FFF9);
        chk("sub_func8", 32'(alu_func[8]), 32'd0);

        in_instr = enc_i({7'h20, 5'd3}, 5'd1, 3'd5, 5'd4);
        cycle();
        chk("srai_b", alu_b, 32'd3);
        chk("srai_func", 32'(alu_func), 32'h105);

        in_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd0);
        cycle();
        chk("addi_x0_rd_we", 32'(rd_we), 32'd0);

        in_pc = 32'h100; in_instr = enc_b(-8, 5'd2, 5'd1, 3'd0);
        cycle();
        chk("beq_target", branch_target, 32'hF8);
        chk("beq_is_branch", 32'(is_branch), 32'd1);

        in_instr = {20'h0, 5'd5, 7'b0001111};
        cycle();
        chk("fence_illegal", 32'(illegal), 32'd1);
        chk("fence_rd_we", 32'(rd_we), 32'd0);

        // Stall with a new instruction waiting: slot frozen, fetch held off
        in_pc = 32'h200; in_instr = enc_r(7'h00, 5'd1, 5'd2, 3'd4, 5'd6);
        cycle();
        out_ready = 1'b0; in_pc = 32'h204; in_instr = enc_i(12'hFFF, 5'd2, 3'd0, 5'd7);
        repeat (3) begin
            cycle();
            chk("stall_pc", out_pc, 32'h200);
        end
        out_ready = 1'b1;
        cycle();
        chk("after_stall_pc", out_pc, 32'h204);
        in_valid = 1'b0;
        cycle();

        // Flush together with a handshake: the incoming instruction never issues
        in_valid = 1'b1; in_pc = 32'h300; in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd8);
        cycle();
        flush = 1'b1; in_pc = 32'h304;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        chk("flushed_not_issued", 32'(out_valid), 32'd0);

        // Reset while stalled takes effect before any clock edge
        in_valid = 1'b1; in_pc = 32'h400; in_instr = {20'hABCDE, 5'd9, 7'h37};
        cycle();
        out_ready = 1'b0; in_valid = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;

        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            regs[1 + ($urandom % 31)] = $urandom;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 16) == 0;
            in_instr  = gen_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
